// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: address field
// layout, storage widths and the fill controller state encoding.
package icache_pkg;
    localparam int TAG_W        = 3;
    localparam int INDEX_W      = 3;
    localparam int OFFSET_W     = 2;
    localparam int WORD_W       = 32;
    localparam int BLOCK_W      = 128;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int BLOCK_ADDR_W = TAG_W + INDEX_W;

    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;
endpackage

// File: rtl/icache_line_store.sv
// Line storage for the instruction cache: valid/tag/data arrays, a single
// write port used by the fill, and the combinational hit compare and word mux.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                we,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_data,
    input  logic                read,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                hit,
    output logic [WORD_W-1:0]   word
);
    logic [NUM_BLOCKS-1:0] valid_reg;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    rd_block;
    logic [WORD_W-1:0]     block_words [WORDS_PER_BLOCK];

    // Only the valid bits need clearing; stale tag/data are masked by them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (we) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_block = data_mem[rd_index];

    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
        assign block_words[gi] = rd_block[gi*WORD_W +: WORD_W];
    end

    assign hit  = read & valid_reg[rd_index] & (tag_mem[rd_index] == rd_tag);
    assign word = hit ? block_words[rd_offset] : '0;
endmodule

// File: rtl/instruction_cache.sv
// Read-only direct-mapped instruction cache: hits are served combinationally,
// misses stall the CPU while a whole 16-byte block is fetched and installed.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic [ADDR_W-1:0]       address,
    output logic [WORD_W-1:0]       instruction,
    output logic                    busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]      mem_readdata,
    input  logic                    mem_busywait
);
    state_t                  state_reg;
    logic                    mem_read_reg;
    logic [BLOCK_ADDR_W-1:0] mem_address_reg;
    logic [BLOCK_W-1:0]      fill_data_reg;
    logic                    seen_busy_reg;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;
    logic                hit;
    logic                unused_byte_bits;

    assign addr_tag         = address[TAG_LSB +: TAG_W];
    assign addr_index       = address[INDEX_LSB +: INDEX_W];
    assign addr_offset      = address[OFFSET_LSB +: OFFSET_W];
    assign unused_byte_bits = ^address[1:0];

    icache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_store (
        .clock     (clock),
        .reset     (reset),
        .we        (state_reg == UPDATE),
        .wr_index  (mem_address_reg[INDEX_W-1:0]),
        .wr_tag    (mem_address_reg[BLOCK_ADDR_W-1:INDEX_W]),
        .wr_data   (fill_data_reg),
        .read      (read),
        .rd_index  (addr_index),
        .rd_tag    (addr_tag),
        .rd_offset (addr_offset),
        .hit       (hit),
        .word      (instruction)
    );

    // The block address is latched at the miss so later PC changes cannot
    // redirect an in-flight fill; the memory must show busy before its data
    // is trusted, which guards against sampling a stale low busywait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_read_reg    <= 1'b0;
            mem_address_reg <= '0;
            fill_data_reg   <= '0;
            seen_busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (read && !hit) begin
                        state_reg       <= MEM_READ;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= {addr_tag, addr_index};
                        seen_busy_reg   <= 1'b0;
                    end
                end
                MEM_READ: begin
                    if (mem_busywait) begin
                        seen_busy_reg <= 1'b1;
                    end else if (seen_busy_reg) begin
                        state_reg     <= UPDATE;
                        mem_read_reg  <= 1'b0;
                        fill_data_reg <= mem_readdata;
                    end
                end
                UPDATE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_read_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read    = mem_read_reg;
    assign mem_address = mem_address_reg;
    assign busywait    = ~reset & ((state_reg != IDLE) | (read & ~hit));
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, hit, conflict replacement,
// reset during a fill, idle behaviour and the top-of-address-space block.
module tb_instruction_cache;
    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int vectors = 0;
    int miscompares = 0;

    instruction_cache #(
        .NUM_BLOCKS (8),
        .ADDR_W     (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // Word w of block b = {w+1, byte address of that word}.
    function automatic logic [127:0] blk(input logic [5:0] b);
        logic [127:0] r;
        logic [15:0]  lo;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            lo = {6'b0, b, 4'b0} + 16'(w * 4);
            r[32*w +: 32] = {16'(w + 1), lo};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Plays the memory side of one block fill; optionally moves the PC
    // mid-fill to confirm the latched block address is kept.
    task automatic do_fill(input string tag, input logic [5:0] exp_maddr, input bit scramble);
        int n;
        logic [9:0] orig;
        n = 0;
        while (!mem_read && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_mem_read"}, 32'(mem_read), 32'd1);
        check({tag, "_mem_address"}, 32'(mem_address), 32'(exp_maddr));
        check({tag, "_busy_in_read"}, 32'(busywait), 32'd1);
        mem_busywait = 1'b1;
        orig = address;
        if (scramble) address = 10'h3FC;
        repeat (3) tick();
        if (scramble) check({tag, "_addr_latched"}, 32'(mem_address), 32'(exp_maddr));
        address = orig;
        mem_readdata = blk(exp_maddr);
        mem_busywait = 1'b0;
        tick();
        check({tag, "_update_memread"}, 32'(mem_read), 32'd0);
        check({tag, "_update_busy"}, 32'(busywait), 32'd1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        read = 1'b0;
        address = '0;
        mem_readdata = '0;
        mem_busywait = 1'b0;
        repeat (2) tick();
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        reset = 1'b0;
        tick();

        // Cold miss at 0x000
        read = 1'b1;
        address = 10'h000;
        #1;
        check("cold_busy_comb", 32'(busywait), 32'd1);
        check("cold_instr_zero", instruction, 32'd0);
        do_fill("cold", 6'h00, 1'b0);
        check("cold_instr", instruction, 32'h0001_0000);
        check("cold_busy_done", 32'(busywait), 32'd0);

        // Same-cycle hit on neighbouring word
        address = 10'h004;
        #1;
        check("hit_instr", instruction, 32'h0002_0004);
        check("hit_busy", 32'(busywait), 32'd0);
        tick();
        check("hit_no_mem_read", 32'(mem_read), 32'd0);

        // Conflict on index 0 with tag 1
        address = 10'h080;
        #1;
        check("conf_busy", 32'(busywait), 32'd1);
        check("conf_instr_zero", instruction, 32'd0);
        do_fill("conf", 6'h08, 1'b1);
        check("conf_instr", instruction, 32'h0001_0080);
        address = 10'h000;
        #1;
        check("conf_old_miss", 32'(busywait), 32'd1);
        do_fill("refill", 6'h00, 1'b0);
        check("refill_instr", instruction, 32'h0001_0000);

        // Reset in the middle of a fill of block 0x01
        address = 10'h010;
        #1;
        check("rmid_busy", 32'(busywait), 32'd1);
        tick();
        check("rmid_mem_read", 32'(mem_read), 32'd1);
        mem_busywait = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("rmid_mem_read_drop", 32'(mem_read), 32'd0);
        check("rmid_busy_rst", 32'(busywait), 32'd0);
        mem_readdata = blk(6'h01);
        mem_busywait = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rmid_abandoned_miss", 32'(busywait), 32'd1);
        check("rmid_abandoned_instr", instruction, 32'd0);
        address = 10'h000;
        #1;
        check("rmid_line0_miss", 32'(busywait), 32'd1);
        do_fill("rfill", 6'h00, 1'b0);
        check("rfill_instr", instruction, 32'h0001_0000);

        // Idle: no fetch, no memory traffic
        read = 1'b0;
        address = 10'h240;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_mem_read", 32'(mem_read), 32'd0);
            check("idle_busy", 32'(busywait), 32'd0);
        end

        // Top of the address space
        read = 1'b1;
        address = 10'h3FC;
        #1;
        check("wrap_busy", 32'(busywait), 32'd1);
        do_fill("wrap", 6'h3F, 1'b0);
        check("wrap_instr", instruction, 32'h0004_03FC);
        check("wrap_busy_done", 32'(busywait), 32'd0);
        address = 10'h3F0;
        #1;
        check("wrap_word0", instruction, 32'h0001_03F0);
        address = 10'h000;
        #1;
        check("line0_kept", instruction, 32'h0001_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 8, meaning number of direct-mapped cache lines (16 bytes each).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning CPU byte-address width.
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port read  input  1  CPU fetch request, level-sensitive.
REQ-006 SHALL have port address  input  ADDR_W  CPU byte address (PC); bits [1:0] ignored.
REQ-007 SHALL have port instruction  output  32  fetched instruction word.
REQ-008 SHALL have port busywait  output  1  CPU stall; high while the fetch is not yet served.
REQ-009 SHALL have port mem_read  output  1  block read request to instruction memory.
REQ-010 SHALL have port mem_address  output  6  block address to memory = address[9:4].
REQ-011 SHALL have port mem_readdata  input  128  returned block; byte k of block at bits [8k+7:8k].
REQ-012 SHALL have port mem_busywait  input  1  memory busy; high from mem_read rise until block valid.

Function
REQ-013 SHALL split address as tag = [9:7], index = [6:4], word offset = [3:2].
REQ-014 SHALL hold per line: valid bit, 3-bit tag, 128-bit data.
REQ-015 SHALL detect hit combinationally: read & valid[index] & (tag_array[index] == tag).
REQ-016 On hit, SHALL drive instruction = data[index] word selected by offset in the same cycle, busywait = 0.
REQ-017 When read = 0, SHALL drive busywait = 0 and start no memory access.
REQ-018 On miss, SHALL drive busywait = 1 combinationally in the same cycle.
REQ-019 SHALL implement FSM states IDLE, MEM_READ, UPDATE.
REQ-020 IDLE -> MEM_READ on posedge when read & !hit; otherwise stay IDLE.
REQ-021 In MEM_READ SHALL drive mem_read = 1, mem_address = {tag, index}, busywait = 1; stay while mem_busywait = 1 or mem_busywait not yet seen high after entry.
REQ-022 MEM_READ -> UPDATE on the first posedge where mem_busywait = 0 after having been seen 1; mem_read drops in UPDATE.
REQ-023 In UPDATE SHALL write mem_readdata to data[index], tag to tag_array[index], set valid[index] = 1; busywait = 1; -> IDLE next posedge.
REQ-024 After UPDATE, the retried fetch SHALL hit in IDLE with busywait = 0; miss-to-instruction penalty = memory latency + 2 cycles.
REQ-025 A miss SHALL replace the indexed line unconditionally (no write-back; read-only cache).
REQ-026 address changes during MEM_READ/UPDATE SHALL NOT alter mem_address; the latched block address SHALL be used.
REQ-027 When no hit, instruction SHALL be 32'h0000_0000.
REQ-028 Address wrap: address 10'h3FC SHALL map to tag 7, index 7, offset 3, mem_address 6'h3F.

Reset
REQ-029 Reset SHALL asynchronously force state IDLE, all valid bits 0, mem_read 0, mem_address 0, busywait 0, instruction 0.
REQ-030 Reset mid-MEM_READ or mid-UPDATE SHALL abandon the fill; no line SHALL become valid; returned data after reset SHALL be ignored.
REQ-031 Tag and data arrays need not be reset.

Structure
REQ-032 SHALL place FSM state enum, TAG_W/INDEX_W/BLOCK_W constants and field-extraction widths in a shared package icache_pkg.
REQ-033 SHALL implement storage (valid/tag/data arrays, write port, hit compare, word mux) in one sub-module icache_line_store.

Verification
REQ-034 Cold miss: reset, read=1, address=0x000 -> busywait=1, mem_read=1, mem_address=0x00; memory returns word0 = 32'h0001_0000 -> UPDATE, then instruction = 32'h0001_0000, busywait=0.
REQ-035 Hit: after REQ-034, address=0x004 -> same-cycle instruction = 32'h0002_0004, busywait=0, mem_read stays 0.
REQ-036 Conflict: address=0x080 (tag 1, index 0) -> miss, mem_address=0x08, line 0 replaced; then address=0x000 misses again.
REQ-037 Reset mid-fill: assert reset during MEM_READ -> mem_read=0 immediately; after release address=0x000 misses again.
REQ-038 Idle/wrap: read=0 for 10 cycles -> no mem_read; then address=0x3FC -> mem_address=0x3F, instruction = byte 15..12 of block.
